flash_bus_arbiter: RTL

//  Shares the DE2-70 word-mode flash bus between two requesters: port 0 (flash tester) and port 1 (system reader).

---
 rtl/flash_bus_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/flash_bus_arbiter.sv
// Round-robin arbiter that shares the word-mode flash bus between the tester (port 0) and the system reader (port 1).
// Optional macro FLASH_ARB_TIMEOUT_EN adds a BUSY_WAIT timeout that reports oERR with oDONE.
module flash_bus_arbiter #(
  parameter int P_STROBE  = 4,
  parameter int P_RDY_DLY = 8,
  parameter int P_TIMEOUT = 2**24
) (
  input  logic        iCLK_28,
  input  logic        iRST,
  input  logic [1:0]  iREQ,
  input  logic [1:0]  iWR,
  input  logic [43:0] iADDR,
  input  logic [31:0] iWDATA,
  output logic [1:0]  oGNT,
  output logic [1:0]  oDONE,
  output logic [15:0] oRDATA,
  output logic        oERR,
  output logic [21:0] oFLASH_A,
  inout  wire  [15:0] FLASH_DQ,
  output logic        oFLASH_CE_N,
  output logic        oFLASH_OE_N,
  output logic        oFLASH_WE_N,
  input  logic        iFLASH_RY_N
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, BUSY_WAIT, DONE
  } state_t;

  localparam int CMAX = (P_STROBE > P_RDY_DLY) ? P_STROBE : P_RDY_DLY;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(P_STROBE - 1);
  localparam logic [CW-1:0] RDY_LAST    = CW'(P_RDY_DLY - 1);
  localparam logic [CW-1:0] CNT_MAX     = CW'(CMAX);

  state_t        state, nextState;
  logic [CW-1:0] cnt;
  logic          rr;
  logic          opWr;
  logic [21:0]   addrReg;
  logic [15:0]   wdataReg;
  logic          winner;
  logic          readyExit;
  logic          timeoutHit;
  logic          errFlag;
  logic          dqEn;

  // Tie goes to the port that did not win last; a lone request wins outright.
  assign winner    = (iREQ == 2'b11) ? ~rr : iREQ[1];
  assign readyExit = (cnt >= RDY_LAST) && iFLASH_RY_N;

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int TW = $clog2(P_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(P_TIMEOUT - 1);
  logic [TW-1:0] tCnt;

  always_ff @(posedge iCLK_28) begin
    if (iRST || state != BUSY_WAIT) tCnt <= '0;
    else                            tCnt <= tCnt + 1'b1;
  end

  assign timeoutHit = (state == BUSY_WAIT) && (tCnt == TIMEOUT_LAST);

  always_ff @(posedge iCLK_28) begin
    if (iRST)                                          errFlag <= 1'b0;
    else if (state == IDLE)                            errFlag <= 1'b0;
    else if (state == BUSY_WAIT && !readyExit && timeoutHit) errFlag <= 1'b1;
  end
`else
  assign timeoutHit = 1'b0;
  assign errFlag    = 1'b0;
`endif

  always_ff @(posedge iCLK_28) begin
    if (iRST) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (|iREQ) nextState = SETUP;
      SETUP:     nextState = STROBE;
      STROBE:    if (cnt == STROBE_LAST) nextState = HOLD;
      HOLD:      nextState = opWr ? BUSY_WAIT : DONE;
      BUSY_WAIT: if (readyExit || timeoutHit) nextState = DONE;
      DONE:      nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_comb begin
    oFLASH_CE_N = 1'b1;
    oFLASH_OE_N = 1'b1;
    oFLASH_WE_N = 1'b1;
    dqEn        = 1'b0;
    oDONE       = 2'b00;
    oERR        = 1'b0;
    case (state)
      SETUP: begin
        oFLASH_CE_N = 1'b0;
        dqEn        = opWr;
      end
      STROBE: begin
        oFLASH_CE_N = 1'b0;
        oFLASH_OE_N = opWr;
        oFLASH_WE_N = ~opWr;
        dqEn        = opWr;
      end
      HOLD: begin
        oFLASH_CE_N = 1'b0;
        dqEn        = opWr;
      end
      DONE: begin
        oDONE = oGNT;
        oERR  = errFlag;
      end
      default: ;
    endcase
  end

  assign FLASH_DQ = dqEn ? wdataReg : 16'hzzzz;
  assign oFLASH_A = addrReg;

  // Phase counter restarts on every state change and saturates so BUSY_WAIT can hold it.
  always_ff @(posedge iCLK_28) begin
    if (iRST || state != nextState) cnt <= '0;
    else if (cnt != CNT_MAX)        cnt <= cnt + 1'b1;
  end

  always_ff @(posedge iCLK_28) begin
    if (iRST) begin
      oGNT     <= 2'b00;
      rr       <= 1'b1;
      opWr     <= 1'b0;
      addrReg  <= '0;
      wdataReg <= '0;
      oRDATA   <= '0;
    end else begin
      if (state == IDLE && |iREQ) begin
        oGNT     <= winner ? 2'b10 : 2'b01;
        opWr     <= iWR[winner];
        addrReg  <= winner ? iADDR[43:22]  : iADDR[21:0];
        wdataReg <= winner ? iWDATA[31:16] : iWDATA[15:0];
      end
      if (state == STROBE && !opWr && cnt == STROBE_LAST)
        oRDATA <= FLASH_DQ;
      if (state == DONE) begin
        oGNT <= 2'b00;
        rr   <= oGNT[1];
      end
    end
  end

endmodule
